// File: rtl/rv32m_pkg.sv
// Shared RV32M divide definitions: funct3 encodings, the M-extension funct7
// value and the divide sequencer state type.
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Magnitude of v when it is a signed operand, otherwise v untouched.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                              input logic             is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division step on the {rem,quo} pair.
module div_restoring_step
  import rv32m_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_trial;
  logic          w_fits;

  // rem < divisor holds between steps, so a non-negative trial always fits
  // in XLEN bits and bit XLEN of the trial acts as its sign.
  assign w_shifted = {i_rem, i_quo[XLEN-1]};
  assign w_trial   = w_shifted - {1'b0, i_divisor};
  assign w_fits    = ~w_trial[XLEN];

  assign o_rem = w_fits ? w_trial[XLEN-1:0] : w_shifted[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/rv32m_div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer: 32-cycle restoring divide with
// sign fix-up, special-case shortcuts and a pipeline stall request.
module rv32m_div_seq
  import rv32m_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  div_state_t      r_state;
  div_state_t      w_next;
  logic [4:0]      r_count;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_divisor;
  logic            r_neg_quo;
  logic            r_neg_rem;
  logic [1:0]      r_funct3;
  logic [XLEN-1:0] r_result;

  logic            w_go;
  logic            w_signed;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_special;
  logic [XLEN-1:0] w_step_rem;
  logic [XLEN-1:0] w_step_quo;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  assign w_go       = i_start & i_funct3[2];
  assign w_signed   = ~i_funct3[0];
  assign w_div_zero = (i_rs2_data == '0);
  assign w_overflow = w_signed && (i_rs1_data == 32'h8000_0000) && (i_rs2_data == '1);
  assign w_special  = w_div_zero | w_overflow;

  div_restoring_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  assign w_quo_fix = r_neg_quo ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_neg_rem ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next = w_special ? DONE : CALC;
      CALC:    if (r_count == 5'd31) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (i_flush) w_next = IDLE;
  end

  // Operands are captured only in the start cycle; later forwarding changes
  // on i_rs1_data/i_rs2_data never reach the datapath.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_funct3  <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go && !i_flush) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= abs_val(i_rs1_data, w_signed);
            r_divisor <= abs_val(i_rs2_data, w_signed);
            r_neg_quo <= w_signed & (i_rs1_data[XLEN-1] ^ i_rs2_data[XLEN-1]);
            r_neg_rem <= w_signed & i_rs1_data[XLEN-1];
            r_funct3  <= i_funct3[1:0];
            if (w_div_zero)
              r_result <= i_funct3[1] ? i_rs1_data : '1;
            else if (w_overflow)
              r_result <= i_funct3[1] ? '0 : 32'h8000_0000;
          end
        end
        CALC: begin
          if (!i_flush) begin
            r_rem   <= w_step_rem;
            r_quo   <= w_step_quo;
            r_count <= r_count + 5'd1;
          end
        end
        FIX: begin
          if (!i_flush) r_result <= r_funct3[1] ? w_rem_fix : w_quo_fix;
        end
        default: ;
      endcase
    end
  end

  assign o_stall  = !i_flush && (((r_state == IDLE) && w_go) ||
                                 (r_state == CALC) || (r_state == FIX));
  assign o_valid  = (r_state == DONE) && !i_flush;
  assign o_result = r_result;

endmodule

// File: tb/tb_rv32m_div_seq.sv
// Self-checking bench for rv32m_div_seq against an arithmetic reference model.
module tb_rv32m_div_seq;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_flush;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [31:0] lastExp = 32'h0;
  int lastStartCyc;
  int lastValidCyc;

  rv32m_div_seq dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_flush    (i_flush),
    .o_stall    (o_stall),
    .o_valid    (o_valid),
    .o_result   (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RISC-V M semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
    case (f3)
      3'b100:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      3'b101:  return a / b;
      3'b110:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    int lat;
    int stallCnt;
    int validAt;
    logic [31:0] exp;
    logic [31:0] got;
    exp = ref_result(f3, a, b);
    lat = is_special(f3, a, b) ? 1 : 34;
    stallCnt = 0;
    validAt = -1;
    got = 32'hx;
    @(negedge clk);
    i_start = 1'b1;
    i_funct3 = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    lastStartCyc = cyc;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (k == 1) begin
          i_start = 1'b0;
          i_rs1_data = $urandom;
          i_rs2_data = $urandom;
        end
      end
      #1;
      if (o_valid) begin
        validAt = k;
        got = o_result;
        lastValidCyc = cyc;
        break;
      end
      if (o_stall) stallCnt++;
    end
    checks++;
    if (validAt !== lat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d want %0d", name, validAt, lat);
    end
    checks++;
    if (stallCnt !== lat) begin
      errors++;
      $display("[TB] FAIL %s stall cycles: got %0d want %0d", name, stallCnt, lat);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s result: got %08h want %08h (a=%08h b=%08h f3=%0b)",
               name, got, exp, a, b, f3);
    end
    lastExp = exp;
  endtask

  task automatic check_quiet(input string name, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      if (o_valid || o_stall || o_result !== lastExp) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL %s quiet: %0d bad cycles, want 0", name, bad);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset stall: got %b want 0", o_stall); end
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset valid: got %b want 0", o_valid); end
    checks++;
    if (o_result !== 32'h0) begin errors++; $display("[TB] FAIL reset result: got %08h want 0", o_result); end
    lastExp = 32'h0;
  endtask

  task automatic test_directed();
    do_op("divu_100_7", 3'b101, 32'd100, 32'd7);
    do_op("remu_100_7", 3'b111, 32'd100, 32'd7);
    do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE);
    do_op("div_m20_m3", 3'b100, 32'hFFFF_FFEC, 32'hFFFF_FFFD);
  endtask

  task automatic test_special();
    do_op("divu_5_0", 3'b101, 32'd5, 32'd0);
    do_op("remu_5_0", 3'b111, 32'd5, 32'd0);
    do_op("div_m5_0", 3'b100, 32'hFFFF_FFFB, 32'd0);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu_8000_ffff", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_flush();
    @(negedge clk);
    i_start = 1'b1;
    i_funct3 = 3'b101;
    i_rs1_data = 32'd1234;
    i_rs2_data = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) i_start = 1'b0;
    end
    i_flush = 1'b1;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin errors++; $display("[TB] FAIL flush stall mask: got %b want 0", o_stall); end
    @(negedge clk);
    i_flush = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_result !== lastExp) begin
      errors++;
      $display("[TB] FAIL flush kill: valid %b result %08h want 0 / %08h", o_valid, o_result, lastExp);
    end
    check_quiet("after_flush", 40);
    do_op("divu_ffff_10", 3'b101, 32'hFFFF_FFFF, 32'h10);
  endtask

  task automatic test_back_to_back();
    int firstStart;
    @(negedge clk);
    i_start = 1'b1;
    i_funct3 = 3'b111;
    i_rs1_data = 32'd77;
    i_rs2_data = 32'd6;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) i_start = 1'b0;
    end
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_stall !== 1'b0 || o_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset outputs: valid %b stall %b result %08h want 0/0/0",
               o_valid, o_stall, o_result);
    end
    lastExp = 32'h0;
    check_quiet("after_reset", 40);
    do_op("b2b_divu_9_3", 3'b101, 32'd9, 32'd3);
    firstStart = lastStartCyc;
    do_op("b2b_remu_10_4", 3'b111, 32'd10, 32'd4);
    checks++;
    if (lastValidCyc - firstStart !== 69) begin
      errors++;
      $display("[TB] FAIL b2b spacing: got %0d want 69", lastValidCyc - firstStart);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 24; n++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      do_op($sformatf("rand%0d", n), f3, a, b);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_funct3 = 3'b100;
    i_rs1_data = 32'h0;
    i_rs2_data = 32'h0;
    i_flush = 1'b0;
    test_reset();
    test_directed();
    test_special();
    test_flush();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
